datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath_pkg.sv | 50 +++++
 rtl/datapath_ram.sv | 56 +++++
 rtl/datapath.sv | 117 +++++++++++
 tb/tb_datapath.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// datapath_pkg: constants and drive-select encoding shared by the datapath
// and the control FSM that sequences it.
//   THRESHOLD_DEF / STEP_DEF : default compare limit and add/subtract amount
//   drives_t                 : the five bus drive requests, one bit each
//   drive_sel_e              : which source owns the bus this cycle
package datapath_pkg;

    localparam int THRESHOLD_DEF = 109;
    localparam int STEP_DEF      = 13;

    typedef struct packed {
        logic i;
        logic plus;
        logic minus;
        logic plus1;
        logic mem;
    } drives_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_I,
        SEL_PLUS,
        SEL_MINUS,
        SEL_PLUS1,
        SEL_MEM
    } drive_sel_e;

    // More than one requester: clearing the lowest set bit leaves something.
    function automatic logic multi_drive(input drives_t d);
        logic [4:0] v;
        v = d;
        return (v & (v - 5'd1)) != 5'd0;
    endfunction

    // Exactly one requester selects its source; zero or several select none,
    // which parks the bus at 0.
    function automatic drive_sel_e drive_select(input drives_t d);
        drive_sel_e sel;
        sel = SEL_NONE;
        if (!multi_drive(d)) begin
            if (d.i)          sel = SEL_I;
            else if (d.plus)  sel = SEL_PLUS;
            else if (d.minus) sel = SEL_MINUS;
            else if (d.plus1) sel = SEL_PLUS1;
            else if (d.mem)   sel = SEL_MEM;
        end
        return sel;
    endfunction

endpackage

// File: rtl/datapath_ram.sv
// datapath_ram: storage array with write arbitration.
//   clock, rst_n          : clock, async active-low reset (blocks writes only;
//                           contents are never cleared)
//   wr_en/wr_addr/wr_data : datapath write port (wins over preload)
//   load_*                : preload write port
//   rd_addr -> rd_data    : combinational datapath read
//   dbg_addr -> dbg_data  : combinational inspection read
module datapath_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    always_comb begin
        we    = 1'b0;
        waddr = wr_addr;
        wdata = wr_data;
        if (wr_en) begin
            we = 1'b1;
        end else if (load_en) begin
            we    = 1'b1;
            waddr = load_addr;
            wdata = load_data;
        end
    end

    // Reset is in the sensitivity list only so that an edge landing while
    // reset is low cannot commit a half-finished sequence's write.
    always_ff @(posedge clock or negedge rst_n) begin
        if (rst_n && we) mem_q[waddr] <= wdata;
    end

    assign rd_data  = mem_q[rd_addr];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/datapath.sv
// datapath: single shared bus with element / index / address registers and a
// memory, sequenced externally by a control FSM.
//   clock, reset            : rising-edge clock, async active-low reset
//   *_write                 : load element / i / address from bus, write memory
//   *_drive                 : bus source requests (i, element+/-STEP, i+1, mem)
//   load_en/addr/data       : preload port into memory
//   dbg_addr -> dbg_data    : combinational memory inspection
//   greater109_out          : element > THRESHOLD
//   equal0_out              : bus == 0
//   bus_conflict            : sticky, set when several drives collide
module datapath
    import datapath_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int THRESHOLD  = THRESHOLD_DEF,
    parameter int STEP       = STEP_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  element_write,
    input  logic                  i_write,
    input  logic                  address_write,
    input  logic                  memory_write,
    input  logic                  i_drive,
    input  logic                  plus13_drive,
    input  logic                  minus13_drive,
    input  logic                  plus1_drive,
    input  logic                  memory_drive,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  greater109_out,
    output logic                  equal0_out,
    output logic                  bus_conflict
);

    localparam logic [DATA_WIDTH-1:0] THR_V  = DATA_WIDTH'(THRESHOLD);
    localparam logic [DATA_WIDTH-1:0] STEP_V = DATA_WIDTH'(STEP);

    logic [DATA_WIDTH-1:0] element_q, element_d;
    logic [ADDR_WIDTH-1:0] i_q, i_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic                  conflict_q, conflict_d;

    logic [DATA_WIDTH-1:0] bus;
    logic [DATA_WIDTH-1:0] mem_rd;
    logic [ADDR_WIDTH-1:0] i_plus1;
    drives_t               drives;
    drive_sel_e            sel;

    assign drives  = '{i: i_drive, plus: plus13_drive, minus: minus13_drive,
                       plus1: plus1_drive, mem: memory_drive};
    assign sel     = drive_select(drives);
    assign i_plus1 = i_q + ADDR_WIDTH'(1);

    // Sums wrap naturally in the register width.
    always_comb begin
        bus = '0;
        case (sel)
            SEL_I:     bus = DATA_WIDTH'(i_q);
            SEL_PLUS:  bus = element_q + STEP_V;
            SEL_MINUS: bus = element_q - STEP_V;
            SEL_PLUS1: bus = DATA_WIDTH'(i_plus1);
            SEL_MEM:   bus = mem_rd;
            default:   bus = '0;
        endcase
    end

    // The bus is built from pre-edge register values, so a register that is
    // both driving and loading sees its old value (read-before-write).
    always_comb begin
        element_d  = element_write ? bus : element_q;
        i_d        = i_write ? ADDR_WIDTH'(bus) : i_q;
        address_d  = address_write ? ADDR_WIDTH'(bus) : address_q;
        conflict_d = conflict_q | multi_drive(drives);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            element_q  <= '0;
            i_q        <= '0;
            address_q  <= '0;
            conflict_q <= 1'b0;
        end else begin
            element_q  <= element_d;
            i_q        <= i_d;
            address_q  <= address_d;
            conflict_q <= conflict_d;
        end
    end

    datapath_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock     (clock),
        .rst_n     (reset),
        .wr_en     (memory_write),
        .wr_addr   (address_q),
        .wr_data   (bus),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .rd_addr   (address_q),
        .rd_data   (mem_rd),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    assign greater109_out = element_q > THR_V;
    assign equal0_out     = bus == '0;
    assign bus_conflict   = conflict_q;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

    localparam int DEPTH = 256;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       element_write, i_write, address_write, memory_write;
    logic       i_drive, plus13_drive, minus13_drive, plus1_drive, memory_drive;
    logic       load_en;
    logic [7:0] load_addr, load_data, dbg_addr;
    logic [7:0] dbg_data;
    logic       greater109_out, equal0_out, bus_conflict;

    always #5 clock = ~clock;

    datapath dut (
        .clock(clock), .reset(reset),
        .element_write(element_write), .i_write(i_write),
        .address_write(address_write), .memory_write(memory_write),
        .i_drive(i_drive), .plus13_drive(plus13_drive),
        .minus13_drive(minus13_drive), .plus1_drive(plus1_drive),
        .memory_drive(memory_drive),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .greater109_out(greater109_out), .equal0_out(equal0_out),
        .bus_conflict(bus_conflict)
    );

    int vectors = 0;
    int miscompares = 0;

    // ---------------- behavioural model ----------------
    logic [7:0] m_elem, m_i, m_addr;
    logic       m_conf;
    logic [7:0] m_mem [DEPTH];
    bit         m_known [DEPTH];
    logic [7:0] pre [DEPTH];

    function automatic int ndrv();
        return $countones({i_drive, plus13_drive, minus13_drive, plus1_drive, memory_drive});
    endfunction

    function automatic logic [7:0] m_bus();
        if (ndrv() != 1) return 8'd0;
        if (i_drive)       return m_i;
        if (plus13_drive)  return m_elem + 8'd13;
        if (minus13_drive) return m_elem - 8'd13;
        if (plus1_drive)   return m_i + 8'd1;
        return m_mem[m_addr];
    endfunction

    function automatic logic [7:0] xf(input logic [7:0] v);
        return (v > 8'd109) ? v - 8'd13 : v + 8'd13;
    endfunction

    always @(posedge clock or negedge reset) begin
        logic [7:0] b;
        if (!reset) begin
            m_elem = 0; m_i = 0; m_addr = 0; m_conf = 0;
        end else begin
            b = m_bus();
            if (memory_write) begin
                m_mem[m_addr] = b; m_known[m_addr] = 1;
            end else if (load_en) begin
                m_mem[load_addr] = load_data; m_known[load_addr] = 1;
            end
            if (ndrv() > 1) m_conf = 1;
            if (element_write) m_elem = b;
            if (i_write)       m_i = b;
            if (address_write) m_addr = b;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clock) begin
        chk("greater109", {7'd0, greater109_out}, {7'd0, m_elem > 8'd109});
        chk("equal0", {7'd0, equal0_out}, {7'd0, m_bus() == 8'd0});
        chk("conflict", {7'd0, bus_conflict}, {7'd0, m_conf});
        if (m_known[dbg_addr]) chk("dbg_data", dbg_data, m_mem[dbg_addr]);
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        element_write = 0; i_write = 0; address_write = 0; memory_write = 0;
        i_drive = 0; plus13_drive = 0; minus13_drive = 0; plus1_drive = 0;
        memory_drive = 0; load_en = 0;
    endtask

    task automatic cyc();
        @(posedge clock); #1;
    endtask

    task automatic preload_random();
        for (int a = 0; a < DEPTH; a++) begin
            idle(); load_en = 1; load_addr = 8'(a); load_data = 8'($urandom);
            pre[a] = load_data;
            cyc();
        end
        idle();
    endtask

    // Control-FSM stand-in: per entry, address<=i, element<=mem, write back
    // element-/+STEP depending on the compare, then i<=i+1.
    task automatic sweep(input int stop_at);
        for (int e = 0; e < DEPTH; e++) begin
            idle(); i_drive = 1; address_write = 1; cyc();
            idle(); memory_drive = 1; element_write = 1; cyc();
            idle(); memory_write = 1;
            if (greater109_out) minus13_drive = 1; else plus13_drive = 1;
            if (e == stop_at) begin
                #2 reset = 0;
                cyc(); reset = 1; idle();
                return;
            end
            cyc();
            idle(); plus1_drive = 1; i_write = 1;
            if (e == DEPTH - 1) begin
                #1 chk("wrap_equal0", {7'd0, equal0_out}, 8'd1);
            end
            cyc();
        end
        idle();
    endtask

    initial begin
        int k;
        idle(); load_addr = 0; load_data = 0; dbg_addr = 0;
        for (int a = 0; a < DEPTH; a++) m_known[a] = 0;
        #1 reset = 0;
        @(negedge clock);
        chk("rst_greater", {7'd0, greater109_out}, 8'd0);
        chk("rst_equal0", {7'd0, equal0_out}, 8'd1);
        chk("rst_conflict", {7'd0, bus_conflict}, 8'd0);
        cyc(); reset = 1;

        // Preload with a few pinned entries for the directed cases.
        preload_random();
        idle(); load_en = 1;
        load_addr = 0; load_data = 109; cyc();
        load_addr = 1; load_data = 110; cyc();
        load_addr = 3; load_data = 250; cyc();
        load_addr = 4; load_data = 5;   cyc();
        load_addr = 5; load_data = 255; cyc();
        idle();

        // Compare boundary: 109 -> 0, 110 -> 1.
        memory_drive = 1; element_write = 1; cyc(); idle();
        @(negedge clock); chk("cmp_109", {7'd0, greater109_out}, 8'd0);
        cyc();
        plus1_drive = 1; address_write = 1; cyc(); idle();
        memory_drive = 1; element_write = 1; cyc(); idle();
        @(negedge clock); chk("cmp_110", {7'd0, greater109_out}, 8'd1);
        cyc();

        // 250 + 13 wraps to 7 at address 3.
        repeat (3) begin plus1_drive = 1; i_write = 1; cyc(); idle(); end
        i_drive = 1; address_write = 1; cyc(); idle();
        memory_drive = 1; element_write = 1; cyc(); idle();
        plus13_drive = 1; memory_write = 1; cyc(); idle();
        dbg_addr = 3; #1 chk("plus_wrap", dbg_data, 8'd7);

        // 5 - 13 wraps to 248 at address 4.
        plus1_drive = 1; i_write = 1; address_write = 1; cyc(); idle();
        memory_drive = 1; element_write = 1; cyc(); idle();
        minus13_drive = 1; memory_write = 1; cyc(); idle();
        dbg_addr = 4; #1 chk("minus_wrap", dbg_data, 8'd248);

        // Index wrap: i=255, plus1_drive+i_write flags zero in the same cycle.
        plus1_drive = 1; address_write = 1; cyc(); idle();
        memory_drive = 1; i_write = 1; cyc(); idle();
        plus1_drive = 1; i_write = 1;
        #1 chk("i_wrap_equal0", {7'd0, equal0_out}, 8'd1);
        cyc(); idle();
        plus1_drive = 1;
        #1 chk("i_after_wrap", {7'd0, equal0_out}, 8'd0);
        cyc(); idle();

        // Collision: bus parked at 0, flag sticky from the next edge.
        i_drive = 1; memory_drive = 1;
        #1 chk("coll_equal0", {7'd0, equal0_out}, 8'd1);
        chk("coll_not_yet", {7'd0, bus_conflict}, 8'd0);
        cyc(); idle();
        #1 chk("coll_set", {7'd0, bus_conflict}, 8'd1);
        repeat (3) cyc();
        chk("coll_sticky", {7'd0, bus_conflict}, 8'd1);
        reset = 0;
        #1 chk("coll_cleared", {7'd0, bus_conflict}, 8'd0);
        cyc(); reset = 1;

        // Randomized traffic, checked every cycle by the compare process.
        for (int n = 0; n < 1500; n++) begin
            idle();
            reset = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 15) == 0) begin
                {i_drive, plus13_drive, minus13_drive, plus1_drive, memory_drive} = 5'($urandom);
            end else begin
                case ($urandom_range(0, 5))
                    0: i_drive = 1;
                    1: plus13_drive = 1;
                    2: minus13_drive = 1;
                    3: plus1_drive = 1;
                    4: memory_drive = 1;
                    default: ;
                endcase
            end
            element_write = ($urandom_range(0, 2) == 0);
            i_write       = ($urandom_range(0, 2) == 0);
            address_write = ($urandom_range(0, 2) == 0);
            memory_write  = ($urandom_range(0, 3) == 0);
            load_en       = ($urandom_range(0, 3) == 0);
            load_addr     = 8'($urandom);
            load_data     = 8'($urandom);
            dbg_addr      = 8'($urandom);
            cyc();
        end
        idle(); reset = 0; cyc(); reset = 1;

        // Sweep interrupted by reset during the write-back of entry k.
        preload_random();
        k = $urandom_range(60, 200);
        sweep(k);
        i_drive = 1;
        #1 chk("rst_i_zero", {7'd0, equal0_out}, 8'd1);
        cyc(); idle();
        for (int a = 0; a < DEPTH; a++) begin
            dbg_addr = 8'(a);
            #1 chk("sweep_partial", dbg_data, (a < k) ? xf(pre[a]) : pre[a]);
        end

        // Full uninterrupted sweep.
        preload_random();
        sweep(-1);
        for (int a = 0; a < DEPTH; a++) begin
            dbg_addr = 8'(a);
            #1 chk("sweep_full", dbg_data, xf(pre[a]));
        end

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
